// File: rtl/uart_wb_bridge.sv
// rtl/uart_wb_bridge.sv - UART command frames to single-beat Wishbone cycles; UART_WB_TIMEOUT_EN enables the inter-byte frame timeout
module uart_wb_bridge #(
    parameter int          DATA_WIDTH     = 32,
    parameter int          ADDR_WIDTH     = 32,
    parameter logic [7:0]  CMD_READ       = 8'h01,
    parameter logic [7:0]  CMD_WRITE      = 8'hAA,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic [7:0]              tx_data,
    output logic                    tx_start,
    input  logic                    tx_busy,
    input  logic                    select_mem,
    output logic                    mem_sel_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i,
    output logic                    rx_overrun
);

    localparam int ADDR_BYTES = ADDR_WIDTH / 8;
    localparam int DATA_BYTES = DATA_WIDTH / 8;
    localparam int MAX_BYTES  = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
    localparam int CNT_W      = $clog2(MAX_BYTES + 1);

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BYTES - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BYTES - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RX_ADDR  = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] WB_WRITE = 3'd3;
    localparam logic [2:0] WB_READ  = 3'd4;
    localparam logic [2:0] TX_BYTE  = 3'd5;
    localparam logic [2:0] TX_WAIT  = 3'd6;

    logic [2:0]            state;
    logic [2:0]            state_next;
    logic [CNT_W-1:0]      cnt;
    logic                  is_write;
    logic                  first_wait;
    logic                  mem_sel_q;
    logic                  overrun_q;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [DATA_WIDTH-1:0] dat_q;
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  cmd_accept;
    logic                  timeout;

    assign cmd_accept = rx_valid && ((rx_data == CMD_WRITE) || (rx_data == CMD_READ));

`ifdef UART_WB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;
    logic            in_frame;

    assign in_frame = (state == RX_ADDR) || (state == RX_DATA);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (rx_valid || !in_frame) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // to_cnt counts silent cycles since the last byte; abort on the last one
    assign timeout = in_frame && !rx_valid && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cmd_accept) state_next = RX_ADDR;
            end
            RX_ADDR: begin
                if (timeout) begin
                    state_next = IDLE;
                end else if (rx_valid && (cnt == ADDR_LAST)) begin
                    state_next = is_write ? RX_DATA : WB_READ;
                end
            end
            RX_DATA: begin
                if (timeout) begin
                    state_next = IDLE;
                end else if (rx_valid && (cnt == DATA_LAST)) begin
                    state_next = WB_WRITE;
                end
            end
            WB_WRITE: begin
                if (wb_ack_i) state_next = IDLE;
            end
            WB_READ: begin
                if (wb_ack_i) state_next = TX_BYTE;
            end
            TX_BYTE: begin
                if (!tx_busy) state_next = TX_WAIT;
            end
            TX_WAIT: begin
                if (!first_wait && !tx_busy) begin
                    state_next = (cnt == DATA_LAST) ? IDLE : TX_BYTE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            is_write   <= 1'b0;
            first_wait <= 1'b0;
            mem_sel_q  <= 1'b0;
            overrun_q  <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            rd_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_accept) begin
                        is_write  <= (rx_data == CMD_WRITE);
                        mem_sel_q <= select_mem;
                        cnt       <= '0;
                    end
                end
                RX_ADDR: begin
                    if (rx_valid) begin
                        adr_q[{cnt, 3'b000} +: 8] <= rx_data;
                        cnt <= (cnt == ADDR_LAST) ? '0 : cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_valid) begin
                        dat_q[{cnt, 3'b000} +: 8] <= rx_data;
                        cnt <= (cnt == DATA_LAST) ? '0 : cnt + 1'b1;
                    end
                end
                WB_READ: begin
                    if (wb_ack_i) begin
                        rd_q <= wb_dat_i;
                        cnt  <= '0;
                    end
                end
                TX_BYTE: begin
                    if (!tx_busy) first_wait <= 1'b1;
                end
                TX_WAIT: begin
                    // tx_busy only rises after the transmitter saw tx_start, so skip one cycle
                    first_wait <= 1'b0;
                    if (!first_wait && !tx_busy) begin
                        cnt <= (cnt == DATA_LAST) ? '0 : cnt + 1'b1;
                    end
                end
                default: ;
            endcase

            if (rx_valid && (state inside {WB_WRITE, WB_READ, TX_BYTE, TX_WAIT})) begin
                overrun_q <= 1'b1;
            end
        end
    end

    always_comb begin
        wb_cyc_o = 1'b0;
        wb_stb_o = 1'b0;
        wb_we_o  = 1'b0;
        wb_sel_o = '0;
        tx_start = 1'b0;
        tx_data  = rd_q[{cnt, 3'b000} +: 8];
        case (state)
            WB_WRITE: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                wb_we_o  = 1'b1;
                wb_sel_o = '1;
            end
            WB_READ: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                wb_sel_o = '1;
            end
            TX_BYTE: begin
                tx_start = !tx_busy;
            end
            default: ;
        endcase
    end

    assign wb_adr_o   = adr_q;
    assign wb_dat_o   = dat_q;
    assign mem_sel_o  = mem_sel_q;
    assign rx_overrun = overrun_q;

endmodule

// File: tb/tb_uart_wb_bridge.sv
// tb/tb_uart_wb_bridge.sv - scoreboard bench for uart_wb_bridge with Wishbone slave and UART transmitter models
module tb_uart_wb_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy = 1'b0;
    logic        select_mem = 1'b0;
    logic        mem_sel_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i = 32'hDEADBEEF;
    logic        wb_ack_i = 1'b0;
    logic        rx_overrun;

    uart_wb_bridge dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .select_mem(select_mem), .mem_sel_o(mem_sel_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .rx_overrun(rx_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic        msel;
        int          delay;
        logic [31:0] rdata;
    } wb_exp_t;

    wb_exp_t    wb_q[$];
    logic [7:0] tx_q[$];
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic report_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s", name);
    endtask

    // Wishbone slave plus scoreboard monitor
    wb_exp_t cur;
    logic    active = 1'b0;
    logic    ack_we = 1'b0;
    int      len = 0;
    int      wcnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            wb_ack_i = 1'b0;
            wb_dat_i = 32'hDEADBEEF;
            active   = 1'b0;
            wcnt     = 0;
        end else begin
            if (wb_ack_i) begin
                if (ack_we) check("idle_after_write_ack", dut.state, dut.IDLE);
                wb_ack_i = 1'b0;
                wb_dat_i = 32'hDEADBEEF;
            end
            if (wb_cyc_o) begin
                if (!active) begin
                    active = 1'b1;
                    len    = 0;
                    wcnt   = 0;
                    if (wb_q.size() == 0) begin
                        report_fail("wb_unexpected_cycle");
                        cur = '{we: 1'b0, adr: 32'h0, dat: 32'h0, msel: 1'b0, delay: 1, rdata: 32'h0};
                    end else begin
                        cur = wb_q.pop_front();
                        check("wb_we", wb_we_o, cur.we);
                        check("wb_stb", wb_stb_o, 1'b1);
                        check("wb_adr", wb_adr_o, cur.adr);
                        check("wb_sel", wb_sel_o, 4'hF);
                        check("mem_sel", mem_sel_o, cur.msel);
                        if (cur.we) check("wb_dat", wb_dat_o, cur.dat);
                    end
                end
                len++;
                wcnt++;
                if (wcnt == cur.delay) begin
                    wb_ack_i = 1'b1;
                    ack_we   = wb_we_o;
                    wb_dat_i = cur.rdata;
                end
            end else if (active) begin
                check("wb_cyc_len", len, cur.delay);
                active = 1'b0;
            end
        end
    end

    // UART transmitter model: busy from the cycle after tx_start for a few cycles
    logic tx_seen = 1'b0;
    logic pend = 1'b0;
    int   bcnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            tx_busy = 1'b0;
            pend    = 1'b0;
            bcnt    = 0;
        end else begin
            tx_seen = tx_start;
            if (tx_seen) begin
                check("tx_start_while_busy", tx_busy, 1'b0);
                if (tx_q.size() == 0) report_fail("tx_unexpected_byte");
                else check("tx_byte", tx_data, tx_q.pop_front());
            end
            if (pend) begin
                tx_busy = 1'b1;
                bcnt    = 3;
                pend    = 1'b0;
            end else if (tx_busy) begin
                if (bcnt == 0) tx_busy = 1'b0;
                else bcnt--;
            end
            if (tx_seen) pend = 1'b1;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] adr, input logic [31:0] dat);
        send_byte(cmd);
        for (int i = 0; i < 4; i++) send_byte(adr[8*i +: 8]);
        if (cmd == 8'hAA) begin
            for (int i = 0; i < 4; i++) send_byte(dat[8*i +: 8]);
        end
    endtask

    task automatic do_write(input logic [31:0] adr, input logic [31:0] dat, input int delay);
        wb_q.push_back('{we: 1'b1, adr: adr, dat: dat, msel: select_mem, delay: delay, rdata: 32'h0});
        send_frame(8'hAA, adr, dat);
    endtask

    task automatic do_read(input logic [31:0] adr, input logic [31:0] rdata, input int delay);
        wb_q.push_back('{we: 1'b0, adr: adr, dat: 32'h0, msel: select_mem, delay: delay, rdata: rdata});
        for (int i = 0; i < 4; i++) tx_q.push_back(rdata[8*i +: 8]);
        send_frame(8'h01, adr, 32'h0);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (dut.state != dut.IDLE && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) report_fail({name, "_idle_timeout"});
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_cyc(input string name);
        int n = 0;
        while (!wb_cyc_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) report_fail({name, "_cyc_timeout"});
    endtask

    function automatic logic [81:0] all_outs();
        return {tx_data, tx_start, mem_sel_o, wb_cyc_o, wb_stb_o, wb_we_o,
                wb_adr_o, wb_dat_o, wb_sel_o, rx_overrun};
    endfunction

    task automatic pulse_reset(input string name);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check({name, "_outputs_zero"}, all_outs(), 82'h0);
        check({name, "_state_idle"}, dut.state, dut.IDLE);
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b1;
        #1;
        check("reset_outputs_zero", all_outs(), 82'h0);
        check("reset_state_idle", dut.state, dut.IDLE);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;

        select_mem = 1'b0;
        do_write(32'h0000_0004, 32'h0000_0094, 1);
        wait_idle("write1");

        select_mem = 1'b1;
        do_read(32'h0000_0010, 32'hA5A5_A5A5, 5);
        wait_idle("read_a5");
        check("mem_sel_held", mem_sel_o, 1'b1);

        do_read(32'h0000_0C08, 32'h1234_5678, 1);
        wait_idle("read_lsb_first");

        select_mem = 1'b0;
        send_byte(8'h55);
        check("ignore_55_state", dut.state, dut.IDLE);
        send_byte(8'h3C);
        check("ignore_3c_state", dut.state, dut.IDLE);
        do_write(32'h8000_0020, 32'hCAFE_BABE, 2);
        wait_idle("write_after_junk");
        check("mem_sel_updated", mem_sel_o, 1'b0);

        check("overrun_clear_before", rx_overrun, 1'b0);
        select_mem = 1'b1;
        do_read(32'h0000_0044, 32'h0BAD_F00D, 5);
        wait_cyc("overrun_read");
        send_byte(8'hAA);
        check("overrun_set", rx_overrun, 1'b1);
        wait_idle("overrun_read");
        do_write(32'h0000_0008, 32'h0000_0001, 1);
        wait_idle("write_after_overrun");
        check("overrun_sticky", rx_overrun, 1'b1);

        send_byte(8'hAA);
        send_byte(8'h11);
        send_byte(8'h22);
        pulse_reset("reset_mid_frame");
        select_mem = 1'b0;
        do_write(32'h0000_0030, 32'h5566_7788, 1);
        wait_idle("write_after_reset");

        select_mem = 1'b1;
        wb_q.push_back('{we: 1'b1, adr: 32'h0000_0040, dat: 32'h0102_0304, msel: 1'b1, delay: 20, rdata: 32'h0});
        send_frame(8'hAA, 32'h0000_0040, 32'h0102_0304);
        wait_cyc("reset_in_cycle");
        pulse_reset("reset_in_cycle");
        do_read(32'h0000_0050, 32'h8899_AABB, 2);
        wait_idle("read_after_reset");

        repeat (5) @(negedge clk);
        check("wb_queue_drained", wb_q.size(), 0);
        check("tx_queue_drained", tx_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_wb_bridge.md
Name: uart_wb_bridge

Overview:
- Command-parsing bridge between the UART byte receiver/transmitter and the Wishbone bus of osiris_i.
- Consumes received UART bytes, decodes CMD_WRITE/CMD_READ frames with little-endian address/data, and issues one single-beat Wishbone master cycle to instruction or data memory.
- For reads, returns the 4 data bytes LSB-first through the UART transmitter.
- Instantiated in osiris_i as U_UART_WB_BRIDGE.

Parameters:
- DATA_WIDTH, 32, Wishbone data width; multiple of 8.
- ADDR_WIDTH, 32, Wishbone address width; multiple of 8.
- CMD_READ, 8'h01, read command byte.
- CMD_WRITE, 8'hAA, write command byte.
- TIMEOUT_CYCLES, 1000000, inter-byte timeout in clk cycles (optional feature only).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- rx_data  input  8  byte from UART receiver
- rx_valid  input  1  one-cycle strobe, rx_data valid
- tx_data  output  8  byte to UART transmitter
- tx_start  output  1  one-cycle strobe to start transmission
- tx_busy  input  1  transmitter busy; rises the cycle after tx_start, falls after the stop bit
- select_mem  input  1  0 = instruction memory, 1 = data memory
- mem_sel_o  output  1  select_mem latched at command acceptance
- wb_cyc_o  output  1  Wishbone cycle
- wb_stb_o  output  1  Wishbone strobe
- wb_we_o  output  1  Wishbone write enable
- wb_adr_o  output  ADDR_WIDTH  Wishbone address
- wb_dat_o  output  DATA_WIDTH  Wishbone write data
- wb_sel_o  output  DATA_WIDTH/8  byte enables; all ones during a cycle
- wb_dat_i  input  DATA_WIDTH  Wishbone read data
- wb_ack_i  input  1  Wishbone acknowledge
- rx_overrun  output  1  sticky; a byte arrived while the bridge was not accepting

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE immediately.
  - All outputs are 0, including tx_data, wb_adr_o, wb_dat_o, wb_sel_o, mem_sel_o and rx_overrun.
  - A reset mid-frame or mid-bus-cycle drops wb_cyc_o/wb_stb_o at once; the partial frame is discarded.
- The state register is named state and the IDLE encoding is a localparam named IDLE; the bench samples both hierarchically.
- States: IDLE, RX_ADDR, RX_DATA, WB_WRITE, WB_READ, TX_BYTE, TX_WAIT.
- IDLE:
  - On rx_valid with CMD_WRITE or CMD_READ: latch the command and select_mem into mem_sel_o, clear the byte counter, go to RX_ADDR.
  - Any other byte is silently ignored; stay in IDLE.
- RX_ADDR:
  - Each rx_valid shifts a byte into the address register, LSB first: byte k lands in bits [8k+7:8k].
  - After ADDR_WIDTH/8 bytes: CMD_WRITE goes to RX_DATA; CMD_READ goes to WB_READ.
- RX_DATA:
  - Same LSB-first collection into the data register.
  - After DATA_WIDTH/8 bytes, go to WB_WRITE.
- WB_WRITE / WB_READ:
  - On the state-entry edge, assert wb_cyc_o = wb_stb_o = 1, wb_we_o = 1 (write) or 0 (read), and drive wb_adr_o, wb_dat_o and wb_sel_o.
  - Hold all of these until the edge where wb_ack_i = 1 is sampled.
  - On that edge: deassert cyc/stb/we. A write returns to IDLE; a read captures wb_dat_i and goes to TX_BYTE.
  - No bus timeout; a missing ack holds the bridge in this state indefinitely.
- TX_BYTE:
  - When tx_busy = 0, drive tx_data with captured-data byte k (LSB first), pulse tx_start for 1 cycle, go to TX_WAIT.
- TX_WAIT:
  - Ignore tx_busy for the first cycle.
  - Then wait for tx_busy = 0 and increment k.
  - After DATA_WIDTH/8 bytes go to IDLE; otherwise go back to TX_BYTE.
- Overrun:
  - rx_valid in WB_WRITE, WB_READ, TX_BYTE or TX_WAIT drops the byte and sets rx_overrun.
  - rx_overrun is cleared only by reset.
- Latency:
  - wb_cyc_o rises 1 cycle after the rx_valid of the last data byte (write) or the last address byte (read).
  - After a write ack, state == IDLE 1 cycle later.
- mem_sel_o holds its value until the next accepted command.

Optional Feature:
- Macro UART_WB_TIMEOUT_EN.
- Defined:
  - A counter resets on every rx_valid.
  - In RX_ADDR or RX_DATA, TIMEOUT_CYCLES cycles without rx_valid abort the frame and return to IDLE. No bus cycle is issued; registers keep their values.
- Undefined: no counter; the bridge waits indefinitely for the remaining frame bytes.

Test Plan:
- Write: bytes AA, 04 00 00 00, 94 00 00 00 -> exactly one WB cycle with adr=0x00000004, dat=0x00000094, we=1, sel=4'hF; state==IDLE 1 cycle after ack.
- Read with ack delayed 5 cycles, wb_dat_i=0xA5A5A5A5: bytes 01, 10 00 00 00 -> adr=0x10, we=0; cyc held 5 cycles; TX bytes A5 A5 A5 A5 with one tx_start each, no tx_start while tx_busy=1.
- Bytes 55 then 3C in IDLE -> no state change, no WB cycle; a following valid AA frame writes correctly.
- Byte pushed during WB_READ -> rx_overrun=1, read response unaffected, overrun stays set until rst.
- rst pulse after 2 address bytes, and again during asserted wb_cyc_o -> all outputs 0 immediately; the next full frame works.
- UART_WB_TIMEOUT_EN with TIMEOUT_CYCLES=100: AA plus 3 address bytes then silence -> IDLE after 100 cycles, no WB cycle.
